// File: rtl/masked_share_gen.sv
// masked_share_gen
//   Input stage for the masked ripple-carry adder. It accepts plaintext
//   operands a/b/c_in over a valid/ready handshake and splits a and b into
//   two Boolean shares each. The masks come from a 32-bit Fibonacci LFSR.
//   The block refills a fresh 2N-bit mask before every accept, so each mask
//   is used exactly once. Shares are held in a single output register stage.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   seed_we, seed_in    reseed strobe / value (0 selects SEED)
//   in_valid, in_ready  upstream handshake
//   a, b, c_in          plaintext operands
//   out_valid,out_ready downstream handshake
//   a0/a1, b0/b1        shares: a0^a1 == a, b0^b1 == b
//   c_out               registered c_in
module masked_share_gen #(
  parameter int          N    = 4,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_we,
  input  logic [31:0]  seed_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] a0,
  output logic [N-1:0] a1,
  output logic [N-1:0] b0,
  output logic [N-1:0] b1,
  output logic         c_out
);

  localparam int MW = 2 * N;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t        state, state_nxt;
  logic [31:0]   l;
  logic [31:0]   l_step;
  logic [MW-1:0] m;
  logic [CW-1:0] cnt;
  logic [N-1:0]  ma, mb;
  logic          accept;

  assign l_step = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  assign ma     = m[MW-1:N];
  assign mb     = m[N-1:0];

  // A reseed in the same cycle wins over an accept, so it masks in_ready
  // rather than letting a transaction consume a mask that is being discarded.
  assign in_ready = (state == ARMED) && !seed_we && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (cnt == CNT_LAST) state_nxt = ARMED;
      ARMED:   if (accept)          state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
    if (seed_we) state_nxt = FILL;
  end

  // ---------------- mask generation ----------------
  // LFSR and mask register advance only while filling; ARMED freezes the
  // mask so the value presented at accept is the one that was just built.
  always_ff @(posedge clk) begin
    if (rst) begin
      l   <= SEED;
      m   <= '0;
      cnt <= '0;
    end else if (seed_we) begin
      l   <= (seed_in == 32'd0) ? SEED : seed_in;
      m   <= '0;
      cnt <= '0;
    end else if (state == FILL) begin
      l   <= l_step;
      m   <= {m[MW-2:0], l[31]};
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // ---------------- output register ----------------
  // Load on accept (even when the previous result drains the same cycle,
  // keeping out_valid high); otherwise clear once downstream consumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
      c_out     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a0        <= a ^ ma;
      a1        <= ma;
      b0        <= b ^ mb;
      b1        <= mb;
      c_out     <= c_in;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_masked_share_gen.sv
// Self-checking bench for masked_share_gen (N=4, SEED=1).
// Inputs are driven 1 time unit after the rising edge; a negedge monitor
// pushes expected shares on accept and pops/compares on consume.
module tb_masked_share_gen;
  localparam int          N      = 4;
  localparam logic [31:0] SEED_P = 32'h0000_0001;

  logic         clk = 1'b0;
  logic         rst, seed_we, in_valid, in_ready, c_in, out_valid, out_ready, c_out;
  logic [31:0]  seed_in;
  logic [N-1:0] a, b, a0, a1, b0, b1;

  masked_share_gen #(.N(N), .SEED(SEED_P)) dut (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_in(seed_in),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c_out(c_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] a, b, a0, a1, b0, b1;
    logic         c;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ml;
  bit          rnd_phase = 0;
  int          nz_a1 = 0;

  // Reference mask: 2N successive LFSR output bits, first bit ends up at MSB.
  task automatic next_mask(output logic [2*N-1:0] mk);
    logic fb;
    mk = '0;
    for (int i = 0; i < 2 * N; i++) begin
      mk = {mk[2*N-2:0], ml[31]};
      fb = ml[31] ^ ml[21] ^ ml[1] ^ ml[0];
      ml = {ml[30:0], fb};
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t         e;
    logic [2*N-1:0] mm;
    if (rst) begin
      q.delete();
      ml = SEED_P;
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sb_shares", 64'({a0, a1, b0, b1, c_out}), 64'({e.a0, e.a1, e.b0, e.b1, e.c}));
          chk("a_xor", 64'(a0 ^ a1), 64'(e.a));
          chk("b_xor", 64'(b0 ^ b1), 64'(e.b));
          if (rnd_phase && a1 != '0) nz_a1++;
        end
      end
      if (seed_we) begin
        ml = (seed_in == 32'd0) ? SEED_P : seed_in;
      end else if (in_valid && in_ready) begin
        next_mask(mm);
        e.a  = a;
        e.b  = b;
        e.a1 = mm[2*N-1:N];
        e.b1 = mm[N-1:0];
        e.a0 = a ^ mm[2*N-1:N];
        e.b0 = b ^ mm[N-1:0];
        e.c  = c_in;
        q.push_back(e);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!in_ready && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic send(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
    int n = 0;
    a = va; b = vb; c_in = vc; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      cyc();
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic reseed(input logic [31:0] v);
    seed_we = 1'b1; seed_in = v;
    cyc();
    seed_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seed_we = 1'b0; seed_in = '0; in_valid = 1'b0;
    a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
    cyc(2);
    chk("rst_outs", 64'({in_ready, out_valid, a0, a1, b0, b1, c_out}), 64'd0);

    // Reset release and zero masks from seed 1
    rst = 1'b0;
    wait_ready("ready_after_rst", 8);
    send(4'hA, 4'h5, 1'b1);
    chk("zero_mask", 64'({out_valid, a0, a1, b0, b1, c_out}), 64'({1'b1, 4'hA, 4'h0, 4'h5, 4'h0, 1'b1}));

    // Random share correctness with the default seed value
    reseed(32'hACE1_2468);
    rnd_phase = 1;
    repeat (1000) send(N'($urandom), N'($urandom), 1'($urandom));
    cyc(2);
    rnd_phase = 0;
    chk("a1_nonzero", 64'(nz_a1 != 0), 64'd1);

    // Back-pressure: outputs frozen, in_ready held low past refill
    out_ready = 1'b0;
    send(4'h3, 4'hC, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("bp_hold", 64'({out_valid, a0, a1, b0, b1, c_out}),
          64'({1'b1, q[0].a0, q[0].a1, q[0].b0, q[0].b1, q[0].c}));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      cyc();
    end
    a = 4'h9; b = 4'h6; c_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_valid_kept", 64'(out_valid), 64'd1);
    cyc(2);

    // Reseed determinism (model tracks the reseed value)
    for (int r = 0; r < 2; r++) begin
      reseed(32'h1234_5678);
      for (int i = 0; i < 4; i++) send(N'(i * 3 + 1), N'(15 - i), 1'(i));
    end
    reseed(32'h0);
    for (int i = 0; i < 4; i++) send(N'(i * 5), N'(i + 7), 1'(i + 1));
    cyc(2);

    // Reseed latency, then collision with an accept attempt
    reseed(32'h0BAD_F00D);
    wait_ready("reseed_latency", 8);
    in_valid = 1'b1; seed_we = 1'b1; seed_in = 32'hDEAD_BEEF;
    #1;
    chk("col_in_ready", 64'(in_ready), 64'd0);
    cyc();
    seed_we = 1'b0; in_valid = 1'b0;
    chk("col_out_valid", 64'(out_valid), 64'd0);
    wait_ready("col_refill", 8);
    send(4'hF, 4'h1, 1'b0);
    cyc(2);

    // Reset while holding a result under back-pressure
    out_ready = 1'b0;
    send(4'h7, 4'h8, 1'b1);
    chk("midrst_pending", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cyc();
    chk("midrst_outs", 64'({in_ready, out_valid, a0, a1, b0, b1, c_out}), 64'd0);
    rst = 1'b0;
    wait_ready("midrst_ready", 8);

    out_ready = 1'b1;
    send(4'h2, 4'hB, 1'b0);
    cyc(3);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/masked_share_gen.md
# masked_share_gen

Upstream input stage for the masked N-bit ripple-carry adder. It takes plaintext operands `a`, `b` and `c_in` through a valid/ready handshake and splits each operand into two Boolean shares using fresh masks from an internal 32-bit LFSR. It then registers `a0/a1/b0/b1/c_out` for the adder's share inputs. Each mask is used for exactly one transaction; after every accept the block refills its mask register before it accepts the next operand.

## Interface
- `N`, default 4: operand width; must match the downstream adder's `N`.
- `SEED`, default 32'hACE1_2468: LFSR value loaded at reset and on a zero reseed; must be nonzero.

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `seed_we`, input, 1: reseed strobe.
- `seed_in`, input, 32: reseed value; 0 means use `SEED`.
- `in_valid`, input, 1: operand valid.
- `in_ready`, output, 1: block can accept an operand.
- `a`, input, N: plaintext operand A.
- `b`, input, N: plaintext operand B.
- `c_in`, input, 1: plaintext carry-in.
- `out_valid`, output, 1: share outputs valid.
- `out_ready`, input, 1: downstream accepts the shares.
- `a0`, `a1`, output, N each: shares of A, with `a0 ^ a1 == a`.
- `b0`, `b1`, output, N each: shares of B, with `b0 ^ b1 == b`.
- `c_out`, output, 1: registered copy of `c_in`; feeds the adder's carry-in.

## Operation
- LFSR `l[31:0]`, Fibonacci form.
  - Per step: output bit = `l[31]`; feedback = `l[31]^l[21]^l[1]^l[0]`; `l <= {l[30:0], feedback}`.
  - The LFSR steps only in the FILL state.
- Mask register `m[2N-1:0]`.
  - Each FILL cycle: `m <= {m[2N-2:0], l[31]}`.
  - `ma = m[2N-1:N]`, `mb = m[N-1:0]`.
- Fill counter `cnt` counts 0 to 2N-1.
- FSM states:
  - FILL: one LFSR step and one mask shift per cycle. When `cnt == 2N-1`, go to ARMED and clear `cnt`.
  - ARMED: masks are fresh. `in_ready = !out_valid || out_ready`.
  - On accept (`in_valid && in_ready`):
    - `a0 <= a ^ ma`, `a1 <= ma`, `b0 <= b ^ mb`, `b1 <= mb`, `c_out <= c_in`.
    - `out_valid <= 1`.
    - Next state is FILL.
- `in_ready` is 0 in every state except ARMED.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` when there is no simultaneous accept.
  - A simultaneous downstream consume and upstream accept keeps `out_valid` at 1 and loads the new data.
  - While `out_valid && !out_ready`, `a0..c_out` hold stable. FILL may continue in the background.
- Reseed:
  - When `seed_we` = 1, in any state: `l <= (seed_in == 0) ? SEED : seed_in`, `m <= 0`, `cnt <= 0`, next state FILL.
  - Stale masks are discarded.
  - `seed_we` takes priority over an accept in the same cycle. `in_ready` is forced to 0 that cycle, so no accept occurs.
  - The output register is not affected.
- Priority: `rst` > `seed_we` > accept / fill.
- No arithmetic is performed. All share operations are bitwise XOR with width N; there is no carry or overflow.

## Timing
- Reset values:
  - Outputs: `in_ready` = 0, `out_valid` = 0, `a0`, `a1`, `b0`, `b1` = 0, `c_out` = 0.
  - Internal: `l` = `SEED`, `m` = 0, `cnt` = 0, state FILL.
- After `rst` deasserts, the block is in FILL for cycles 0 to 2N-1. `in_ready` first goes to 1 in cycle 2N (cycle 8 for N=4).
- Latency: an accept at edge k produces `out_valid` = 1 and the shares immediately after edge k. That is one register stage.
- Throughput: at most one transaction every 2N+1 cycles (2N fill cycles plus one ARMED cycle).
- Reseed asserted in cycle t: ARMED again in cycle t+1+2N.
- `rst` asserted mid-fill or mid-hold: at the next edge, all state goes to the reset values and any pending output is dropped.

## Test plan
- **Reset and zero masks:** `SEED`=32'h0000_0001, N=4. After reset, `in_ready` rises at cycle 8. Drive `a`=4'hA, `b`=4'h5, `c_in`=1 → `a0`=4'hA, `a1`=0, `b0`=4'h5, `b1`=0, `c_out`=1. The first 8 LFSR output bits from seed 1 are 0.
- **Share correctness:** 1000 random operands with default `SEED` and `out_ready`=1 → every output satisfies `a0^a1==a` and `b0^b1==b`. Across transactions `a1 != 0` at least once, and no mask pair repeats on consecutive transactions.
- **Back-pressure:** hold `out_ready`=0 after the first accept → the outputs stay frozen and `in_ready` stays 0 even after refill completes. Raise `out_ready` → `in_ready` goes to 1 in that same cycle, and a simultaneous accept loads the new shares without dropping `out_valid`.
- **Reseed determinism:** drive `seed_we` with `seed_in`=32'h1234_5678, capture the shares for 4 transactions, reseed with the same value, repeat the same operands → identical shares. Reseed with `seed_in`=0 → sequence equals the one after reset with `SEED`.
- **Reseed collision:** `seed_we`=1 in the same cycle as `in_valid`=1 while ARMED → no accept, `out_valid` unchanged, `in_ready`=0 for the next 8 cycles.
- **Mid-operation reset:** assert `rst` while `out_valid`=1 and `out_ready`=0 → next cycle all outputs are 0 and `in_ready`=0. `in_ready` returns 8 cycles after `rst` deasserts.
